// File: rtl/aes_ctr_pkg.sv
// Shared types for the AES-CTR counter-block generator.
// Block width, block type and FSM state encoding.
package aes_ctr_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ctr_state_e;

endpackage

// File: rtl/aes_ctr_lane_add.sv
// One lane of the counter fan-out: base plus a fixed lane offset.
// wrap_o marks a lane that lands on zero; the top masks a message's first block.
module aes_ctr_lane_add #(
  parameter int CTR_W = 128,
  parameter int OFF   = 0
) (
  input  logic [CTR_W-1:0] base_i,
  output logic [CTR_W-1:0] sum_o,
  output logic             wrap_o
);

  assign sum_o  = base_i + CTR_W'(OFF);
  assign wrap_o = (sum_o == '0);

endmodule

// File: rtl/aes_ctr_counter_gen.sv
// AES-CTR counter-block stream: LANES blocks per beat, registered AXI-stream out.
// Tracks block count for tkeep/tlast and a sticky low-field wrap flag.
module aes_ctr_counter_gen
  import aes_ctr_pkg::*;
#(
  parameter int LANES = 1,
  parameter int CTR_W = 128,
  parameter int LEN_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  aes_block_t                   input_iv,
  input  logic [LEN_W-1:0]             num_blocks,
  output logic                         busy,
  output logic                         done,
  output logic                         ctr_wrapped,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  output logic [LANES-1:0]             m_axis_tkeep,
  output logic [AES_BLOCK_W*LANES-1:0] m_axis_tdata
);

  ctr_state_e state_q, state_d;
  aes_block_t iv_q, iv_d;
  logic [CTR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic wrapped_q, wrapped_d;
  logic valid_q, valid_d;
  logic last_q, last_d;
  logic [LANES-1:0] keep_q, keep_d;
  logic [LANES-1:0] wrap_q, wrap_d;
  logic [AES_BLOCK_W*LANES-1:0] data_q, data_d;

  logic [CTR_W-1:0] sum_w [LANES];
  logic [LANES-1:0] zero_w;
  logic             hs;
  aes_block_t       lane;

  // Lanes are computed from next-state base so the output stage is a register
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_ctr_lane_add #(
      .CTR_W (CTR_W),
      .OFF   (g)
    ) u_add (
      .base_i (base_d),
      .sum_o  (sum_w[g]),
      .wrap_o (zero_w[g])
    );
  end

  assign hs = valid_q & m_axis_tready;

  always_comb begin
    state_d   = state_q;
    iv_d      = iv_q;
    base_d    = base_q;
    rem_d     = rem_q;
    wrapped_d = wrapped_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          iv_d      = input_iv;
          base_d    = input_iv[CTR_W-1:0];
          rem_d     = num_blocks;
          wrapped_d = 1'b0;
          state_d   = (num_blocks == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hs) begin
          base_d = base_q + CTR_W'(LANES);
          rem_d  = (rem_q <= LEN_W'(LANES)) ? '0
                 : rem_q - LEN_W'(LANES);
          if (|(wrap_q & keep_q)) wrapped_d = 1'b1;
          if (last_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == RUN);
    last_d  = valid_d && (rem_d <= LEN_W'(LANES));
    data_d  = '0;
    keep_d  = '0;
    wrap_d  = '0;
    lane    = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = iv_d;
      lane[CTR_W-1:0] = sum_w[i];
      if (valid_d) data_d[i*AES_BLOCK_W +: AES_BLOCK_W] = lane;
      keep_d[i] = valid_d && (rem_d > LEN_W'(i));
      // The very first block of a message has no predecessor to wrap from
      wrap_d[i] = valid_d && zero_w[i]
                && !(i == 0 && state_q == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      iv_q      <= '0;
      base_q    <= '0;
      rem_q     <= '0;
      wrapped_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      keep_q    <= '0;
      wrap_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      iv_q      <= iv_d;
      base_q    <= base_d;
      rem_q     <= rem_d;
      wrapped_q <= wrapped_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      keep_q    <= keep_d;
      wrap_q    <= wrap_d;
      data_q    <= data_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign ctr_wrapped   = wrapped_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tdata  = data_q;

endmodule

// File: tb/tb_aes_ctr_counter_gen.sv
// Bench: three generator configurations driven in parallel.
// Each is checked against a block-index model of the counter stream.
module tb_aes_ctr_counter_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, abort, tready;
  logic [127:0] iv;
  logic [31:0]  nb;

  logic tv0, tl0, dn0, bz0, wr0;
  logic tv1, tl1, dn1, bz1, wr1;
  logic tv2, tl2, dn2, bz2, wr2;
  logic [0:0]   tk0, tk1;
  logic [3:0]   tk2;
  logic [127:0] td0, td1;
  logic [511:0] td2;

  logic [2:0]    tv_a, tl_a, dn_a, bz_a, wr_a;
  logic [7:0]    tk_a [3];
  logic [1023:0] td_a [3];

  int total = 0;
  int bad   = 0;

  aes_ctr_counter_gen #(.LANES(1), .CTR_W(128), .LEN_W(32)) d0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .input_iv(iv), .num_blocks(nb),
    .busy(bz0), .done(dn0), .ctr_wrapped(wr0),
    .m_axis_tready(tready), .m_axis_tvalid(tv0),
    .m_axis_tlast(tl0), .m_axis_tkeep(tk0), .m_axis_tdata(td0));

  aes_ctr_counter_gen #(.LANES(1), .CTR_W(32), .LEN_W(32)) d1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .input_iv(iv), .num_blocks(nb),
    .busy(bz1), .done(dn1), .ctr_wrapped(wr1),
    .m_axis_tready(tready), .m_axis_tvalid(tv1),
    .m_axis_tlast(tl1), .m_axis_tkeep(tk1), .m_axis_tdata(td1));

  aes_ctr_counter_gen #(.LANES(4), .CTR_W(64), .LEN_W(32)) d2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .input_iv(iv), .num_blocks(nb),
    .busy(bz2), .done(dn2), .ctr_wrapped(wr2),
    .m_axis_tready(tready), .m_axis_tvalid(tv2),
    .m_axis_tlast(tl2), .m_axis_tkeep(tk2), .m_axis_tdata(td2));

  assign tv_a = {tv2, tv1, tv0};
  assign tl_a = {tl2, tl1, tl0};
  assign dn_a = {dn2, dn1, dn0};
  assign bz_a = {bz2, bz1, bz0};
  assign wr_a = {wr2, wr1, wr0};
  assign tk_a[0] = {7'b0, tk0};
  assign tk_a[1] = {7'b0, tk1};
  assign tk_a[2] = {4'b0, tk2};
  assign td_a[0] = {896'b0, td0};
  assign td_a[1] = {896'b0, td1};
  assign td_a[2] = {512'b0, td2};

  function automatic int ln(input int k);
    return (k == 2) ? 4 : 1;
  endfunction

  function automatic int cw(input int k);
    return (k == 0) ? 128 : (k == 1) ? 32 : 64;
  endfunction

  function automatic logic [127:0] fmask(input int w);
    if (w >= 128) return '1;
    return (128'd1 << w) - 128'd1;
  endfunction

  // Block number b of a message: low field counts up mod 2^w, rest fixed
  function automatic logic [127:0] blk(input logic [127:0] v,
                                       input int w, input int b);
    logic [127:0] m;
    m = fmask(w);
    return (v & ~m) | ((v + 128'(b)) & m);
  endfunction

  task automatic run_stream(input logic [127:0] v, input int n,
                            input int rmode, input int abort_at,
                            input bit stray);
    int  sent [3];
    bit  act [3];
    bit  due [3];
    bit  wexp [3];
    bit  nxt, ended;
    int  stall, b;
    logic [7:0] ek;
    logic [127:0] exp_l;
    stall = 0;
    ended = 1'b0;
    iv = v; nb = 32'(n); start = 1'b1; abort = 1'b0; tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sent[k] = 0; act[k] = (n != 0); due[k] = (n == 0); wexp[k] = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (tv_a[k] !== act[k]) begin
          bad++;
          $display("FAIL tvalid d%0d cyc%0d got=%b want=%b", k, c, tv_a[k], act[k]);
        end
        total++;
        if (dn_a[k] !== due[k]) begin
          bad++;
          $display("FAIL done d%0d cyc%0d got=%b want=%b", k, c, dn_a[k], due[k]);
        end
        total++;
        if (bz_a[k] !== (act[k] | due[k])) begin
          bad++;
          $display("FAIL busy d%0d cyc%0d got=%b want=%b", k, c, bz_a[k], act[k] | due[k]);
        end
        total++;
        if (wr_a[k] !== wexp[k]) begin
          bad++;
          $display("FAIL ctr_wrapped d%0d cyc%0d got=%b want=%b", k, c, wr_a[k], wexp[k]);
        end
        if (act[k]) begin
          ek = '0;
          for (int i = 0; i < ln(k); i++) ek[i] = (sent[k] + i < n);
          total++;
          if (tk_a[k] !== ek) begin
            bad++;
            $display("FAIL tkeep d%0d cyc%0d got=%h want=%h", k, c, tk_a[k], ek);
          end
          total++;
          if (tl_a[k] !== (sent[k] + ln(k) >= n)) begin
            bad++;
            $display("FAIL tlast d%0d cyc%0d got=%b want=%b", k, c, tl_a[k], sent[k] + ln(k) >= n);
          end
          for (int i = 0; i < ln(k); i++) begin
            if (sent[k] + i < n) begin
              exp_l = blk(v, cw(k), sent[k] + i);
              total++;
              if (td_a[k][i*128 +: 128] !== exp_l) begin
                bad++;
                $display("FAIL tdata d%0d lane%0d cyc%0d got=%h want=%h",
                         k, i, c, td_a[k][i*128 +: 128], exp_l);
              end
            end
          end
        end
      end
      if (!act[0] && !act[1] && !act[2] && !due[0] && !due[1] && !due[2]) begin
        ended = 1'b1;
        break;
      end
      tready = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rmode == 2 && sent[0] == 1 && stall < 3) begin
        tready = 1'b0;
        stall++;
      end
      if (abort_at > 0 && act[0] && sent[0] == abort_at) abort = 1'b1;
      if (stray && c == 0) begin
        start = 1'b1; iv = ~v; nb = 32'(n + 5);
      end
      for (int k = 0; k < 3; k++) begin
        nxt = 1'b0;
        if (act[k] && abort) begin
          act[k] = 1'b0;
        end else if (act[k] && tready) begin
          for (int i = 0; i < ln(k); i++) begin
            b = sent[k] + i;
            if (b < n && b >= 1 && (blk(v, cw(k), b) & fmask(cw(k))) == '0)
              wexp[k] = 1'b1;
          end
          sent[k] += ln(k);
          if (sent[k] >= n) begin
            act[k] = 1'b0;
            nxt = 1'b1;
          end
        end
        due[k] = nxt;
      end
    end
    total++;
    if (!ended) begin
      bad++;
      $display("FAIL stream_timeout got=running want=idle");
    end
    start = 1'b0;
    abort = 1'b0;
    tready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; tready = 1'b1;
    iv = '0; nb = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({tv_a[k], tl_a[k], dn_a[k], bz_a[k], wr_a[k]} !== 5'b0 ||
          tk_a[k] !== 8'b0 || td_a[k] !== '0) begin
        bad++;
        $display("FAIL reset_state d%0d got=%b%b%b%b%b keep=%h want=0",
                 k, tv_a[k], tl_a[k], dn_a[k], bz_a[k], wr_a[k], tk_a[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_stream(128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF, 4, 0, 0, 1'b0);
    run_stream(128'h01234567_89ABCDEF_012389AB_FFFFFFFF, 2, 0, 0, 1'b0);
    run_stream(128'hFEDCBA98_76543210_00000000_00000000, 6, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_stream(128'h11112222_33334444_55556666_7777FFFE, 3, 2, 0, 1'b0);
  endtask

  task automatic test_zero_and_busy();
    run_stream(128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A, 0, 0, 0, 1'b0);
    run_stream(128'h00000000_00000000_00000000_FFFFFFFD, 3, 0, 0, 1'b1);
  endtask

  task automatic test_abort();
    run_stream(128'hCAFEBABE_DEADBEEF_01020304_05060708, 10, 0, 2, 1'b0);
    run_stream(128'h0, 1, 0, 0, 1'b0);
  endtask

  task automatic test_rst_mid();
    iv = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;
    nb = 32'd10; start = 1'b1; tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({tv_a[k], tl_a[k], dn_a[k], bz_a[k], wr_a[k]} !== 5'b0 ||
          tk_a[k] !== 8'b0 || td_a[k] !== '0) begin
        bad++;
        $display("FAIL rst_mid d%0d got=%b%b%b%b%b keep=%h want=0",
                 k, tv_a[k], tl_a[k], dn_a[k], bz_a[k], wr_a[k], tk_a[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [127:0] v;
    for (int t = 0; t < 8; t++) begin
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (t % 2 == 0) v[31:0] = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
      if (t == 3) v[63:0] = 64'hFFFFFFFF_FFFFFFFF - 64'($urandom_range(0, 6));
      run_stream(v, $urandom_range(0, 12), 1, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_zero_and_busy();
    test_abort();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
